// File: rtl/nand_pkg.sv
// nand_pkg
//   Definitions shared by the NAND flash responder, the controller-side
//   command FSM and the bench: opcode constants, the responder state
//   encoding and the bit positions of the status byte.
//   No ports (package).
package nand_pkg;

    // Command opcodes recognised by the responder
    localparam logic [7:0] NAND_CMD_RESET  = 8'hFF;
    localparam logic [7:0] NAND_CMD_READID = 8'h90;
    localparam logic [7:0] NAND_CMD_STATUS = 8'h70;
    localparam logic [7:0] NAND_CMD_READ0  = 8'h00;
    localparam logic [7:0] NAND_CMD_READ1  = 8'h30;

    // Responder states
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ADDR_ID     = 3'd1,
        ST_READ_ID     = 3'd2,
        ST_READ_STATUS = 3'd3,
        ST_ADDR_PG     = 3'd4,
        ST_BUSY        = 3'd5,
        ST_READ_PAGE   = 3'd6
    } nand_state_e;

    // Status byte bit positions
    localparam int STAT_WP_BIT   = 7;   // 1 = not write protected
    localparam int STAT_RDY_BIT  = 6;   // device ready
    localparam int STAT_ARDY_BIT = 5;   // array ready (same as RDY here)

    // Build the status byte from the write-protect pin and ready flag
    function automatic logic [7:0] nand_status_byte(input logic wp_n, input logic rdy);
        logic [7:0] s;
        s                = 8'h00;
        s[STAT_WP_BIT]   = wp_n;
        s[STAT_RDY_BIT]  = rdy;
        s[STAT_ARDY_BIT] = rdy;
        return s;
    endfunction

endpackage

// File: rtl/nand_strobe_edge.sv
// nand_strobe_edge
//   Registers one active-low strobe every cycle and flags its rising edge
//   (low in the previous cycle, high now). The register resets to 1 so a
//   strobe held high through reset never produces a spurious edge.
// Ports
//   clk_i     in  1  clock
//   rst_i     in  1  asynchronous active-high reset
//   strobe_i  in  1  strobe from the pad
//   rise_o    out 1  combinational rise pulse
module nand_strobe_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic strobe_i,
    output logic rise_o
);

    logic strobe_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            strobe_q <= 1'b1;
        end else begin
            strobe_q <= strobe_i;
        end
    end

    assign rise_o = ~strobe_q & strobe_i;

endmodule

// File: rtl/nand_flash_responder.sv
// nand_flash_responder
//   Device end of the ndf_* NAND pin interface. Latches command and address
//   bytes on WE_n rising edges, answers reset, read-ID, read-status and page
//   read, and drives R/B_n. Page data is the pattern col[7:0] ^ row[7:0].
//   The pad tristate (ndf_io = ndf_io_oe ? ndf_io_out : 'z) lives in the
//   enclosing pad wrapper.
// Ports
//   clk10       in  1  clock, strobes sampled on rising edge
//   rst         in  1  asynchronous active-high reset
//   ndf_ce_n    in  1  chip enable (active low)
//   ndf_cle     in  1  command latch enable
//   ndf_ale     in  1  address latch enable
//   ndf_we_n    in  1  write strobe
//   ndf_re_n    in  1  read strobe
//   ndf_wp_n    in  1  write protect (status bit 7 only)
//   ndf_io_in   in  8  bus value from the pad
//   ndf_io_out  out 8  bus value to drive
//   ndf_io_oe   out 1  pad output enable
//   ndf_r_b_n   out 1  ready / busy_n
module nand_flash_responder
    import nand_pkg::*;
#(
    parameter logic [39:0] ID_BYTES   = 40'hEC_D3_51_95_58,
    parameter logic [15:0] RESET_BUSY = 16'd50,
    parameter logic [15:0] READ_BUSY  = 16'd250,
    parameter logic [15:0] PAGE_BYTES = 16'd2112
) (
    input  logic       clk10,
    input  logic       rst,
    input  logic       ndf_ce_n,
    input  logic       ndf_cle,
    input  logic       ndf_ale,
    input  logic       ndf_we_n,
    input  logic       ndf_re_n,
    input  logic       ndf_wp_n,
    input  logic [7:0] ndf_io_in,
    output logic [7:0] ndf_io_out,
    output logic       ndf_io_oe,
    output logic       ndf_r_b_n
);

    logic we_edge, re_edge;
    logic we_rise, re_rise;

    nand_strobe_edge u_we_edge (
        .clk_i    (clk10),
        .rst_i    (rst),
        .strobe_i (ndf_we_n),
        .rise_o   (we_edge)
    );

    nand_strobe_edge u_re_edge (
        .clk_i    (clk10),
        .rst_i    (rst),
        .strobe_i (ndf_re_n),
        .rise_o   (re_edge)
    );

    assign we_rise = we_edge & ~ndf_ce_n;
    assign re_rise = re_edge & ~ndf_ce_n;

    nand_state_e state_q, state_d;
    nand_state_e prior_q, prior_d;   // state to resume after READ_STATUS
    nand_state_e ret_q,   ret_d;     // state entered when busy completes
    logic [15:0] cnt_q,   cnt_d;
    logic        rb_q,    rb_d;
    logic [15:0] col_q,   col_d;
    logic [23:0] row_q,   row_d;
    logic [2:0]  acnt_q,  acnt_d;    // saturates at 6 = "more than five"
    logic [2:0]  ptr_q,   ptr_d;

    always_ff @(posedge clk10 or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            prior_q <= ST_IDLE;
            ret_q   <= ST_IDLE;
            cnt_q   <= 16'd0;
            rb_q    <= 1'b1;
            col_q   <= 16'd0;
            row_q   <= 24'd0;
            acnt_q  <= 3'd0;
            ptr_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            prior_q <= prior_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            rb_q    <= rb_d;
            col_q   <= col_d;
            row_q   <= row_d;
            acnt_q  <= acnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prior_d = prior_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        rb_d    = rb_q;
        col_d   = col_q;
        row_d   = row_q;
        acnt_d  = acnt_q;
        ptr_d   = ptr_q;

        // Busy countdown runs regardless of CE_n and of a status detour.
        // Low for exactly N cycles: N-1 down to 0, released on the next edge.
        if (!rb_q) begin
            if (cnt_q == 16'd0) begin
                rb_d = 1'b1;
                if (state_q == ST_BUSY) state_d = ret_q;
                if (prior_q == ST_BUSY) prior_d = ret_q;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end

        if (we_rise) begin
            if (ndf_cle && !ndf_ale) begin
                if (ndf_io_in == NAND_CMD_RESET) begin
                    state_d = ST_BUSY;
                    ret_d   = ST_IDLE;
                    prior_d = ST_IDLE;
                    cnt_d   = RESET_BUSY - 16'd1;
                    rb_d    = 1'b0;
                    acnt_d  = 3'd0;
                end else if (ndf_io_in == NAND_CMD_STATUS) begin
                    // Repeated 70h keeps the original state to resume
                    if (state_q != ST_READ_STATUS) prior_d = state_d;
                    state_d = ST_READ_STATUS;
                end else if (state_q == ST_BUSY) begin
                    // other commands ignored while busy
                end else if (state_q == ST_READ_STATUS) begin
                    state_d = prior_d;
                end else begin
                    case (ndf_io_in)
                        NAND_CMD_READID: state_d = ST_ADDR_ID;
                        NAND_CMD_READ0: begin
                            state_d = ST_ADDR_PG;
                            acnt_d  = 3'd0;
                        end
                        NAND_CMD_READ1: begin
                            if (state_q == ST_ADDR_PG && acnt_q == 3'd5) begin
                                state_d = ST_BUSY;
                                ret_d   = ST_READ_PAGE;
                                cnt_d   = READ_BUSY - 16'd1;
                                rb_d    = 1'b0;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end else if (ndf_ale && !ndf_cle) begin
                if (state_q == ST_ADDR_ID) begin
                    state_d = ST_READ_ID;
                    ptr_d   = 3'd0;
                end else if (state_q == ST_ADDR_PG) begin
                    case (acnt_q)
                        3'd0:    col_d[7:0]   = ndf_io_in;
                        3'd1:    col_d[15:8]  = ndf_io_in;
                        3'd2:    row_d[7:0]   = ndf_io_in;
                        3'd3:    row_d[15:8]  = ndf_io_in;
                        3'd4:    row_d[23:16] = ndf_io_in;
                        default: ;
                    endcase
                    if (acnt_q != 3'd6) acnt_d = acnt_q + 3'd1;
                end
            end
        end else if (re_rise) begin
            // WE latch has priority: an RE edge in the same cycle is dropped
            if (state_q == ST_READ_ID) begin
                ptr_d = (ptr_q == 3'd4) ? 3'd0 : ptr_q + 3'd1;
            end else if (state_q == ST_READ_PAGE) begin
                col_d = (col_q == PAGE_BYTES - 16'd1) ? 16'd0 : col_q + 16'd1;
            end
        end
    end

    logic [7:0] id_byte;
    always_comb begin
        case (ptr_q)
            3'd0:    id_byte = ID_BYTES[39:32];
            3'd1:    id_byte = ID_BYTES[31:24];
            3'd2:    id_byte = ID_BYTES[23:16];
            3'd3:    id_byte = ID_BYTES[15:8];
            default: id_byte = ID_BYTES[7:0];
        endcase
    end

    logic reading;
    assign reading = (state_q == ST_READ_ID) || (state_q == ST_READ_STATUS) ||
                     (state_q == ST_READ_PAGE);

    always_comb begin
        ndf_io_out = 8'h00;
        case (state_q)
            ST_READ_ID:     ndf_io_out = id_byte;
            ST_READ_STATUS: ndf_io_out = nand_status_byte(ndf_wp_n, rb_q);
            ST_READ_PAGE:   ndf_io_out = col_q[7:0] ^ row_q[7:0];
            default:        ndf_io_out = 8'h00;
        endcase
    end

    assign ndf_io_oe = ~ndf_ce_n & ~ndf_re_n & reading;
    assign ndf_r_b_n = rb_q;

    // Upper row bits are captured for a future array model; the data
    // pattern only uses the low byte.
    logic unused_row_bits;
    assign unused_row_bits = ^row_q[23:8];

endmodule
